// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
package keypad_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } frame_result_t;

    localparam frame_result_t RESULT_NONE = 5'b0_0000;

    // Entry r drives row r low; index 0 is the reset row.
    localparam logic [3:0][3:0] ROW_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } key_state_t;

    // Exactly one active bit yields its index; zero or several (ghosting) yield NONE.
    function automatic frame_result_t decode_frame(input logic [15:0] bits);
        frame_result_t res;
        logic [4:0]    ones;
        res  = RESULT_NONE;
        ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                ones     = ones + 5'd1;
                res.code = 4'(i);
            end
        end
        if (ones == 5'd1) begin
            res.valid = 1'b1;
        end else begin
            res = RESULT_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - frame-level debounce and press/release state machine
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_end,
    input  frame_result_t result,
    output logic [3:0]    key_code,
    output logic          key_valid,
    output logic          key_held
);

    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(DEB_CNT);
    localparam logic [CW-1:0] STABLE_ONE = CW'(1);

    key_state_t    state_q, state_d;
    frame_result_t prev_q, prev_d;
    logic [CW-1:0] stable_q, stable_d;
    logic [3:0]    code_d;
    logic          valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASED;
            prev_q    <= RESULT_NONE;
            stable_q  <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            key_code  <= code_d;
            key_valid <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        code_d   = key_code;
        valid_d  = 1'b0;
        if (frame_end) begin
            prev_d = result;
            if (result == prev_q) begin
                stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + STABLE_ONE;
            end else begin
                stable_d = STABLE_ONE;
            end
            // A saturated count re-evaluates every frame, so a changed key under a held press still commits.
            if (stable_d == STABLE_MAX) begin
                case (state_q)
                    ST_RELEASED: begin
                        if (result.valid) begin
                            state_d = ST_PRESSED;
                            code_d  = result.code;
                            valid_d = 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!result.valid) begin
                            state_d = ST_RELEASED;
                        end else if (result.code != key_code) begin
                            code_d  = result.code;
                            valid_d = 1'b1;
                        end
                    end
                    default: state_d = ST_RELEASED;
                endcase
            end
        end
    end

    assign key_held = (state_q == ST_PRESSED);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with frame decode and debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Key_In,
    output logic [3:0] Key_Row,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic [15:0]   frame, frame_next;
    logic          dwell_last, frame_end;
    frame_result_t result;

    assign dwell_last = (dwell == DWELL_LAST);
    assign frame_end  = dwell_last && (row == 2'd3);

    // Row 3's sample is merged combinationally so the decode sees the whole frame on its last cycle.
    always_comb begin
        frame_next = frame;
        if (dwell_last) begin
            frame_next[{row, 2'b00} +: 4] = ~Key_In;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dwell <= '0;
            row   <= 2'd0;
            frame <= 16'd0;
        end else begin
            frame <= frame_next;
            if (dwell_last) begin
                dwell <= '0;
                row   <= row + 2'd1;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign Key_Row = ROW_PATTERN[row];
    assign result  = decode_frame(frame_next);

    keypad_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk       (CLK),
        .rst_n     (RSTn),
        .frame_end (frame_end),
        .result    (result),
        .key_code  (Key_Code),
        .key_valid (Key_Valid),
        .key_held  (Key_Held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a matrix keypad model
module tb_keypad_scanner;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] Key_In;
    logic [3:0] Key_Row;
    logic [3:0] Key_Code;
    logic       Key_Valid;
    logic       Key_Held;

    logic [15:0] mask = 16'h0000;
    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int dbl_cnt = 0;
    logic valid_prev = 1'b0;
    int base;

    keypad_scanner #(.SCAN_DIV(4), .DEB_CNT(2)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Key_In    (Key_In),
        .Key_Row   (Key_Row),
        .Key_Code  (Key_Code),
        .Key_Valid (Key_Valid),
        .Key_Held  (Key_Held)
    );

    always #5 CLK = ~CLK;

    // Pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        Key_In = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (Key_Row[r] == 1'b0 && mask[4*r+c]) Key_In[c] = 1'b0;
    end

    always @(posedge CLK) begin
        if (Key_Valid === 1'b1) begin
            valid_cnt++;
            if (valid_prev) dbl_cnt++;
        end
        valid_prev = (Key_Valid === 1'b1);
    end

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        repeat (16 * n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] rows [4];
        rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        mask = 16'h0000;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({Key_Row, Key_Code, Key_Valid, Key_Held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got row=%b code=%h v=%b h=%b expected row=1110 code=0 v=0 h=0",
                     Key_Row, Key_Code, Key_Valid, Key_Held);
        end
        RSTn = 1'b1;
        base = valid_cnt;
        for (int i = 1; i <= 5; i++) begin
            repeat (4) @(posedge CLK);
            #1;
            checks++;
            if (Key_Row !== rows[i % 4]) begin
                errors++;
                $display("FAIL idle_row_%0d: got %b expected %b", i, Key_Row, rows[i % 4]);
            end
        end
        repeat (44) @(posedge CLK);
        #1;
        checks++;
        if (valid_cnt - base !== 0 || Key_Held !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got pulses=%0d held=%b expected pulses=0 held=0", valid_cnt - base, Key_Held);
        end
    endtask

    task automatic test_single_press();
        mask = 16'h1 << 9;
        do_reset();
        base = valid_cnt;
        wait_frames(1);
        checks++;
        if (Key_Valid !== 1'b0 || Key_Held !== 1'b0) begin
            errors++;
            $display("FAIL press9_early: got v=%b h=%b expected v=0 h=0", Key_Valid, Key_Held);
        end
        wait_frames(1);
        checks++;
        if ({Key_Valid, Key_Code, Key_Held} !== {1'b1, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL press9_commit: got v=%b code=%0d h=%b expected v=1 code=9 h=1", Key_Valid, Key_Code, Key_Held);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (Key_Valid !== 1'b0) begin
            errors++;
            $display("FAIL press9_strobe_width: got v=%b expected v=0", Key_Valid);
        end
        repeat (15) @(posedge CLK);
        wait_frames(1);
        checks++;
        if (Key_Held !== 1'b1 || valid_cnt - base !== 1) begin
            errors++;
            $display("FAIL press9_hold: got h=%b pulses=%0d expected h=1 pulses=1", Key_Held, valid_cnt - base);
        end
    endtask

    task automatic test_bounce();
        mask = 16'h1 << 9;
        do_reset();
        base = valid_cnt;
        for (int f = 0; f < 6; f++) begin
            mask = (f % 2 == 0) ? (16'h1 << 9) : 16'h0000;
            wait_frames(1);
            checks++;
            if (Key_Held !== 1'b0) begin
                errors++;
                $display("FAIL bounce_held_f%0d: got h=%b expected h=0", f, Key_Held);
            end
        end
        checks++;
        if (valid_cnt - base !== 0) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d expected 0", valid_cnt - base);
        end
    endtask

    task automatic test_ghost();
        mask = (16'h1 << 1) | (16'h1 << 14);
        do_reset();
        base = valid_cnt;
        wait_frames(4);
        checks++;
        if (valid_cnt - base !== 0 || Key_Held !== 1'b0) begin
            errors++;
            $display("FAIL ghost_none: got pulses=%0d h=%b expected pulses=0 h=0", valid_cnt - base, Key_Held);
        end
        mask = 16'h1 << 1;
        wait_frames(1);
        checks++;
        if (Key_Valid !== 1'b0) begin
            errors++;
            $display("FAIL ghost_release_early: got v=%b expected v=0", Key_Valid);
        end
        wait_frames(1);
        checks++;
        if ({Key_Valid, Key_Code, Key_Held} !== {1'b1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL ghost_commit1: got v=%b code=%0d h=%b expected v=1 code=1 h=1", Key_Valid, Key_Code, Key_Held);
        end
        wait_frames(1);
        checks++;
        if (valid_cnt - base !== 1) begin
            errors++;
            $display("FAIL ghost_pulses: got %0d expected 1", valid_cnt - base);
        end
    endtask

    task automatic test_release_repress();
        mask = 16'h1 << 9;
        do_reset();
        base = valid_cnt;
        wait_frames(2);
        mask = 16'h0000;
        wait_frames(1);
        checks++;
        if (Key_Held !== 1'b1) begin
            errors++;
            $display("FAIL release_held_1f: got h=%b expected h=1", Key_Held);
        end
        wait_frames(1);
        checks++;
        if ({Key_Valid, Key_Code, Key_Held} !== {1'b0, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL release_2f: got v=%b code=%0d h=%b expected v=0 code=9 h=0", Key_Valid, Key_Code, Key_Held);
        end
        mask = 16'h1 << 3;
        wait_frames(1);
        checks++;
        if (Key_Valid !== 1'b0 || Key_Code !== 4'd9) begin
            errors++;
            $display("FAIL repress_early: got v=%b code=%0d expected v=0 code=9", Key_Valid, Key_Code);
        end
        wait_frames(1);
        checks++;
        if ({Key_Valid, Key_Code, Key_Held} !== {1'b1, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL repress_commit3: got v=%b code=%0d h=%b expected v=1 code=3 h=1", Key_Valid, Key_Code, Key_Held);
        end
        wait_frames(1);
        checks++;
        if (valid_cnt - base !== 2) begin
            errors++;
            $display("FAIL repress_pulses: got %0d expected 2", valid_cnt - base);
        end
    endtask

    task automatic test_mid_reset();
        mask = 16'h1 << 5;
        do_reset();
        wait_frames(2);
        checks++;
        if (Key_Valid !== 1'b1 || Key_Code !== 4'd5) begin
            errors++;
            $display("FAIL midrst_commit5: got v=%b code=%0d expected v=1 code=5", Key_Valid, Key_Code);
        end
        wait_frames(1);
        repeat (8) @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({Key_Row, Key_Code, Key_Valid, Key_Held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_async: got row=%b code=%0d v=%b h=%b expected row=1110 code=0 v=0 h=0",
                     Key_Row, Key_Code, Key_Valid, Key_Held);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        base = valid_cnt;
        wait_frames(1);
        checks++;
        if (Key_Valid !== 1'b0 || Key_Held !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: got v=%b h=%b expected v=0 h=0", Key_Valid, Key_Held);
        end
        wait_frames(1);
        checks++;
        if ({Key_Valid, Key_Code, Key_Held} !== {1'b1, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL midrst_redetect: got v=%b code=%0d h=%b expected v=1 code=5 h=1", Key_Valid, Key_Code, Key_Held);
        end
        wait_frames(2);
        checks++;
        if (valid_cnt - base !== 1) begin
            errors++;
            $display("FAIL midrst_pulses: got %0d expected 1", valid_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_release_repress();
        test_mid_reset();
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL valid_back_to_back: got %0d double-cycle strobes expected 0", dbl_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
